// File: rtl/exp3_fluxo_dados_pkg.sv
// Shared constants for the experiment-3 datapath: default widths, ROM image
// and the terminal address of the counter.
package exp3_defs;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 4;

    localparam logic [3:0] TERMINAL_COUNT = 4'd15;

    // Entry i sits at slice [i]; listed from address 15 down to address 0.
    localparam logic [15:0][3:0] ROM_CONTENT = {
        4'b0100, 4'b0001, 4'b1000, 4'b1000,
        4'b0100, 4'b0100, 4'b0010, 4'b0010,
        4'b0001, 4'b0001, 4'b0010, 4'b0100,
        4'b1000, 4'b0100, 4'b0010, 4'b0001
    };

endpackage

// File: rtl/exp3_fluxo_dados_if.sv
// Command/status bundle between the experiment-3 control unit (master) and
// the datapath (slave), plus the debug taps.
interface exp3_fluxo_dados_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              zeraC;
    logic              contaC;
    logic              zeraR;
    logic              registraR;
    logic [DATA_W-1:0] chaves;
    logic              fimC;
    logic              igual;
    logic              maior;
    logic              menor;
    logic              jogada_feita;
    logic [ADDR_W-1:0] db_contagem;
    logic [DATA_W-1:0] db_memoria;
    logic [DATA_W-1:0] db_chaves;

    modport master (
        output zeraC, contaC, zeraR, registraR, chaves,
        input  fimC, igual, maior, menor, jogada_feita,
        input  db_contagem, db_memoria, db_chaves
    );

    modport slave (
        input  zeraC, contaC, zeraR, registraR, chaves,
        output fimC, igual, maior, menor, jogada_feita,
        output db_contagem, db_memoria, db_chaves
    );
endinterface

// File: rtl/exp3_rom_16x4.sv
// Fixed 16x4 table of expected plays, asynchronous read.
module exp3_rom_16x4
    import exp3_defs::*;
(
    input  logic [3:0] addr,
    output logic [3:0] data
);
    always_comb begin
        data = ROM_CONTENT[0];
        case (addr)
            4'd0:  data = ROM_CONTENT[0];
            4'd1:  data = ROM_CONTENT[1];
            4'd2:  data = ROM_CONTENT[2];
            4'd3:  data = ROM_CONTENT[3];
            4'd4:  data = ROM_CONTENT[4];
            4'd5:  data = ROM_CONTENT[5];
            4'd6:  data = ROM_CONTENT[6];
            4'd7:  data = ROM_CONTENT[7];
            4'd8:  data = ROM_CONTENT[8];
            4'd9:  data = ROM_CONTENT[9];
            4'd10: data = ROM_CONTENT[10];
            4'd11: data = ROM_CONTENT[11];
            4'd12: data = ROM_CONTENT[12];
            4'd13: data = ROM_CONTENT[13];
            4'd14: data = ROM_CONTENT[14];
            4'd15: data = ROM_CONTENT[15];
        endcase
    end
endmodule

// File: rtl/exp3_fluxo_dados.sv
// Experiment-3 datapath: address counter, ROM, switch register, magnitude
// comparator and switch-activity edge detector.
module exp3_fluxo_dados
    import exp3_defs::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    exp3_fluxo_dados_if.slave    bus
);
    logic [ADDR_W-1:0] contagem;
    logic [DATA_W-1:0] registro;
    logic [DATA_W-1:0] memoria;
    logic              chaves_hist;
    logic              chaves_ativas;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)           contagem <= '0;
        else if (bus.zeraC)   contagem <= '0;
        else if (bus.contaC)  contagem <= contagem + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)              registro <= '0;
        else if (bus.zeraR)      registro <= '0;
        else if (bus.registraR)  registro <= bus.chaves;
    end

    // Remembers whether any switch was up last cycle, so only the first
    // cycle of activity after an all-zero period raises jogada_feita.
    assign chaves_ativas = |bus.chaves;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) chaves_hist <= 1'b0;
        else        chaves_hist <= chaves_ativas;
    end

    exp3_rom_16x4 u_rom (
        .addr (contagem),
        .data (memoria)
    );

    assign bus.fimC         = (contagem == TERMINAL_COUNT);
    assign bus.igual        = (registro == memoria);
    assign bus.maior        = (registro >  memoria);
    assign bus.menor        = (registro <  memoria);
    assign bus.jogada_feita = chaves_ativas & ~chaves_hist;
    assign bus.db_contagem  = contagem;
    assign bus.db_memoria   = memoria;
    assign bus.db_chaves    = registro;
endmodule
